mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3 (legal 1..7), max consecutive data grants while fetch waits.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch read request, held until if_ready.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_rdata  output  32  fetch read data, valid while if_ready.
REQ-007 if_ready  output  1  fetch completion pulse.
REQ-008 dm_req  input  1  data request, held until dm_ready.
REQ-009 dm_we  input  1  data write enable (1=write, 0=read).
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  data write data.
REQ-012 dm_be  input  4  data byte enables.
REQ-013 dm_rdata  output  32  data read data, valid while dm_ready.
REQ-014 dm_ready  output  1  data completion pulse.
REQ-015 mem_req, mem_we  output  1 each  shared memory request/write enable.
REQ-016 mem_addr, mem_wdata  output  32 each  shared memory address/write data.
REQ-017 mem_be  output  4  shared memory byte enables.
REQ-018 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-019 mem_ack  input  1  memory single-cycle completion.
REQ-020 stall_if, stall_mem  output  1 each  pipeline stall requests to hazard/stall control.

Function
REQ-021 FSM states: IDLE, IF_BUSY, DM_BUSY, RESP.
REQ-022 IDLE: grant DM if dm_req and not (if_req and starve_cnt==STARVE_LIMIT); else grant IF if if_req; else stay.
REQ-023 Grant: at posedge, latch winner's addr/we/wdata/be (IF: we=0, be=4'hF, wdata=0) into registers, mem_req<=1, go to IF_BUSY/DM_BUSY.
REQ-024 BUSY: mem_req and all mem_* outputs held stable from latched registers until mem_ack sampled high.
REQ-025 mem_ack in BUSY: mem_req<=0; owner's rdata register <= mem_rdata (reads only; writes leave dm_rdata unchanged); owner's ready<=1; go to RESP.
REQ-026 RESP: exactly one cycle, ready high, no new grant, next state IDLE; ready cleared on exit.
REQ-027 Latency: req seen in IDLE at edge N -> mem_req high cycle N+1; ack at edge M -> ready high cycle M+1; minimum req-to-ready 3 cycles (ack in first busy cycle).
REQ-028 Requester shall drop or replace req by end of its RESP cycle; arbiter ignores req during RESP.
REQ-029 starve_cnt (3 bits): +1 on each DM grant while if_req high, saturating at STARVE_LIMIT; cleared on IF grant; unchanged otherwise.
REQ-030 stall_if = if_req & ~if_ready; stall_mem = dm_req & ~dm_ready; combinational.
REQ-031 mem_ack in IDLE or RESP ignored, no state change.
REQ-032 Request deasserted mid-BUSY: transaction still completes, ready pulses once.
REQ-033 if_rdata/dm_rdata hold last value until next completed read of the same requester.

Reset
REQ-034 rst low, any state including mid-transaction: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, starve_cnt=0, immediately (asynchronous).
REQ-035 After rst rises, first grant evaluated at first posedge.

Verification
REQ-036 IF only: if_req=1, if_addr=0x100, ack 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=F, if_ready one cycle, if_rdata=0xDEADBEEF, stall_if low in ready cycle.
REQ-037 Simultaneous: if_req=dm_req=1, dm_we=1, dm_addr=0x2000, dm_wdata=0x55AA, dm_be=0x3 -> DM granted first with mem_we=1, be=0x3; dm_rdata unchanged; IF granted next.
REQ-038 Starvation: if_req held, dm_req reissued every RESP, STARVE_LIMIT=3 -> exactly 3 DM grants, then IF grant, starve_cnt=0.
REQ-039 Reset mid-DM_BUSY: rst low between edges -> mem_req=0 at once; after release, no ready pulse, pending reqs re-arbitrated.
REQ-040 Spurious mem_ack in IDLE and RESP -> no ready pulse, no state change; req dropped mid-BUSY -> single ready pulse on ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between instruction fetch and data access
// Ports: clk; rst (asynchronous, active-low); fetch port if_req/if_addr -> if_rdata/if_ready;
//        data port dm_req/dm_we/dm_addr/dm_wdata/dm_be -> dm_rdata/dm_ready;
//        memory port mem_req/mem_we/mem_addr/mem_wdata/mem_be -> mem_rdata/mem_ack;
//        stall_if/stall_mem stall requests to hazard control.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  state_t state, state_nx;
  logic [2:0] starve_cnt;
  logic idle, grant_dm, grant_if, done;
  // data normally wins; once it has won LIMIT times in a row over a waiting fetch, fetch goes first
  always_comb begin
    idle = state == IDLE;
    grant_dm = idle && dm_req && !(if_req && starve_cnt == LIMIT);
    grant_if = idle && !grant_dm && if_req;
    done = (state == IF_BUSY || state == DM_BUSY) && mem_ack;
    state_nx = idle ? (grant_dm ? DM_BUSY : grant_if ? IF_BUSY : IDLE) :
               state == RESP ? IDLE :
               mem_ack ? RESP : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      starve_cnt <= '0;
    end else begin
      if_ready <= done && state == IF_BUSY;
      dm_ready <= done && state == DM_BUSY;
      if (grant_dm || grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_dm && dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
        mem_be    <= grant_dm ? dm_be : 4'hF;
      end
      if (done) mem_req <= 1'b0;
      if (done && state == IF_BUSY) if_rdata <= mem_rdata;
      if (done && state == DM_BUSY && !mem_we) dm_rdata <= mem_rdata;
      if (grant_if) starve_cnt <= '0;
      else if (grant_dm && if_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 3'd1;
    end
  end
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and a randomized scoreboard run for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LIMIT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0] dm_be = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ready, dm_ready, mem_req, mem_we, stall_if, stall_mem;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  logic [31:0] phys [logic [31:0]];
  logic [31:0] refm [logic [31:0]];

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!mem_req && n < 8) begin
      tick();
      n++;
    end
    chk(name, 32'(mem_req), 32'd1);
  endtask

  task automatic ack(input logic [31:0] rd);
    mem_ack = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  function automatic logic [31:0] seed_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : seed_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : seed_val(a);
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 | {27'd0, 3'($urandom_range(0, 7)), 2'b00};
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    string t = $sformatf("vec%0d", i);
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr; dm_we = 1'b1; dm_wdata = 32'hFFFF_0000; dm_be = 4'h5;
    end
    tick();
    chk({t, ".grant_req"}, 32'(mem_req), 32'd1);
    chk({t, ".addr"}, mem_addr, v.addr);
    chk({t, ".we"}, 32'(mem_we), 32'(v.exp_we));
    chk({t, ".be"}, 32'(mem_be), 32'(v.exp_be));
    chk({t, ".wdata"}, mem_wdata, v.exp_wdata);
    repeat (v.delay) tick();
    chk({t, ".held_req"}, 32'(mem_req), 32'd1);
    chk({t, ".held_addr"}, mem_addr, v.addr);
    chk({t, ".ready_early"}, 32'({if_ready, dm_ready}), 32'd0);
    chk({t, ".stall_wait"}, 32'(v.is_dm ? stall_mem : stall_if), 32'd1);
    ack(v.rdata);
    chk({t, ".ready"}, 32'({if_ready, dm_ready}), v.is_dm ? 32'd1 : 32'd2);
    chk({t, ".resp_req"}, 32'(mem_req), 32'd0);
    chk({t, ".stall_ready"}, 32'(v.is_dm ? stall_mem : stall_if), 32'd0);
    chk({t, ".if_rdata"}, if_rdata, v.exp_if);
    chk({t, ".dm_rdata"}, dm_rdata, v.exp_dm);
    if_req = 1'b0;
    dm_req = 1'b0;
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    chk({t, ".ready_once"}, 32'({if_ready, dm_ready}), 32'd0);
    chk({t, ".if_rdata_hold"}, if_rdata, v.exp_if);
    chk({t, ".dm_rdata_hold"}, dm_rdata, v.exp_dm);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,         4'hF, 2, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h2004, 32'h0BAD_F00D, 4'hF, 0, 32'h1234_5678, 1'b0, 4'hF, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'h2000, 32'h55AA,      4'h3, 1, 32'hFFFF_FFFF, 1'b1, 4'h3, 32'h55AA,      32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 32'h104,  32'h0,         4'hF, 0, 32'hCAFE_F00D, 1'b0, 4'hF, 32'h0,         32'hCAFE_F00D, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'h2008, 32'h0,         4'hC, 3, 32'h0,         1'b0, 4'hC, 32'h0,         32'hCAFE_F00D, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h108,  32'h0,         4'hF, 1, 32'h1357_9BDF, 1'b0, 4'hF, 32'h0,         32'h1357_9BDF, 32'h0};

    // asynchronous reset takes effect before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    chk("reset.mem_be", 32'(mem_be), 32'd0);
    chk("reset.ready", 32'({if_ready, dm_ready}), 32'd0);
    chk("reset.if_rdata", if_rdata, 32'd0);
    chk("reset.dm_rdata", dm_rdata, 32'd0);
    chk("reset.stall", 32'({stall_if, stall_mem}), 32'd0);
    repeat (2) tick();
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // simultaneous requests: data write first, fetch next
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h55AA; dm_be = 4'h3;
    tick();
    chk("sim.dm_addr", mem_addr, 32'h2000);
    chk("sim.dm_we", 32'(mem_we), 32'd1);
    chk("sim.dm_be", 32'(mem_be), 32'h3);
    chk("sim.stall_if", 32'(stall_if), 32'd1);
    ack(32'hFFFF_FFFF);
    chk("sim.dm_ready", 32'(dm_ready), 32'd1);
    chk("sim.dm_rdata_kept", dm_rdata, 32'h0);
    dm_req = 1'b0;
    wait_grant("sim.if_grant");
    chk("sim.if_addr", mem_addr, 32'h300);
    chk("sim.if_we", 32'(mem_we), 32'd0);
    chk("sim.if_be", 32'(mem_be), 32'hF);
    ack(32'h0303_0303);
    chk("sim.if_ready", 32'(if_ready), 32'd1);
    chk("sim.if_rdata", if_rdata, 32'h0303_0303);
    if_req = 1'b0;
    tick();

    // starvation: fetch held, data reissued each response
    if_req = 1'b1; if_addr = 32'h400; dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      dm_addr = 32'h2100 + 32'(4 * k);
      wait_grant($sformatf("starve.grant%0d", k));
      chk($sformatf("starve.owner%0d", k), mem_addr, k == 3 ? 32'h400 : dm_addr);
      ack(32'(k));
      chk($sformatf("starve.ready%0d", k), 32'({if_ready, dm_ready}), k == 3 ? 32'd2 : 32'd1);
    end
    dm_req = 1'b0;
    wait_grant("starve.final_if");
    chk("starve.final_if_addr", mem_addr, 32'h400);
    ack(32'h4444);
    if_req = 1'b0;
    tick();

    // reset between edges while data owns the memory port
    if_req = 1'b1; if_addr = 32'h500; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2200;
    tick();
    chk("rstmid.busy", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.mem_req", 32'(mem_req), 32'd0);
    chk("rstmid.mem_addr", mem_addr, 32'd0);
    chk("rstmid.mem_be", 32'(mem_be), 32'd0);
    chk("rstmid.rdata", if_rdata | dm_rdata, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid.regrant", 32'(mem_req), 32'd1);
    chk("rstmid.regrant_addr", mem_addr, 32'h2200);
    chk("rstmid.no_ready", 32'({if_ready, dm_ready}), 32'd0);
    ack(32'h2222_2222);
    chk("rstmid.dm_ready", 32'(dm_ready), 32'd1);
    dm_req = 1'b0;
    wait_grant("rstmid.if_grant");
    chk("rstmid.if_addr", mem_addr, 32'h500);
    ack(32'h5555_5555);
    if_req = 1'b0;
    tick();

    // spurious acks in idle and response, fetch dropped while busy
    mem_ack = 1'b1;
    repeat (2) begin
      tick();
      chk("spur.idle_req", 32'(mem_req), 32'd0);
      chk("spur.idle_ready", 32'({if_ready, dm_ready}), 32'd0);
    end
    mem_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h600;
    tick();
    chk("spur.grant", 32'(mem_req), 32'd1);
    if_req = 1'b0;
    tick();
    chk("drop.still_busy", 32'(mem_req), 32'd1);
    chk("drop.addr", mem_addr, 32'h600);
    mem_ack = 1'b1; mem_rdata = 32'h600D_600D;
    tick();
    chk("drop.ready", 32'(if_ready), 32'd1);
    chk("drop.if_rdata", if_rdata, 32'h600D_600D);
    mem_rdata = 32'h0BAD_0BAD;
    tick();
    chk("spur.resp_ready", 32'({if_ready, dm_ready}), 32'd0);
    chk("spur.resp_req", 32'(mem_req), 32'd0);
    tick();
    chk("spur.after_ready", 32'({if_ready, dm_ready}), 32'd0);
    chk("spur.after_req", 32'(mem_req), 32'd0);
    chk("spur.if_rdata_hold", if_rdata, 32'h600D_600D);
    mem_ack = 1'b0;

    rst = 1'b0;
    tick();
    rst = 1'b1;

    begin : random_phase
      int owner, mstarve;
      bit cool, e_if_ready, e_dm_ready, gdm;
      logic [31:0] t_addr, t_wdata, e_if_rdata, e_dm_rdata;
      logic t_we;
      logic [3:0] t_be;
      logic s_if_req, s_dm_req, s_dm_we, s_ack, s_mreq, s_mwe;
      logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata, s_maddr, s_mwdata;
      logic [3:0] s_dm_be, s_mbe;
      owner = 0; mstarve = 0; cool = 1'b0;
      t_addr = '0; t_wdata = '0; t_we = 1'b0; t_be = '0;
      e_if_rdata = '0; e_dm_rdata = '0;
      for (int c = 0; c < 3000; c++) begin
        s_if_req = if_req; s_if_addr = if_addr;
        s_dm_req = dm_req; s_dm_we = dm_we; s_dm_addr = dm_addr; s_dm_wdata = dm_wdata; s_dm_be = dm_be;
        s_ack = mem_ack; s_mreq = mem_req; s_mwe = mem_we; s_maddr = mem_addr; s_mwdata = mem_wdata; s_mbe = mem_be;
        tick();
        if (s_mreq && s_ack && s_mwe) phys[s_maddr] = merge(phys_rd(s_maddr), s_mwdata, s_mbe);
        // one transaction in flight at a time; a completion is followed by one response cycle
        e_if_ready = 1'b0;
        e_dm_ready = 1'b0;
        if (cool) cool = 1'b0;
        else if (owner != 0) begin
          if (s_ack) begin
            if (owner == 1) begin
              e_if_ready = 1'b1;
              e_if_rdata = ref_rd(t_addr);
            end else begin
              e_dm_ready = 1'b1;
              if (t_we) refm[t_addr] = merge(ref_rd(t_addr), t_wdata, t_be);
              else e_dm_rdata = ref_rd(t_addr);
            end
            owner = 0;
            cool = 1'b1;
          end
        end else begin
          gdm = s_dm_req && !(s_if_req && mstarve == LIMIT);
          if (gdm) begin
            owner = 2; t_addr = s_dm_addr; t_we = s_dm_we; t_wdata = s_dm_wdata; t_be = s_dm_be;
            if (s_if_req && mstarve < LIMIT) mstarve++;
          end else if (s_if_req) begin
            owner = 1; t_addr = s_if_addr; t_we = 1'b0; t_wdata = '0; t_be = 4'hF;
            mstarve = 0;
          end
        end
        chk("rnd.mem_req", 32'(mem_req), 32'(owner != 0));
        if (owner != 0) begin
          chk("rnd.mem_addr", mem_addr, t_addr);
          chk("rnd.mem_we", 32'(mem_we), 32'(t_we));
          chk("rnd.mem_be", 32'(mem_be), 32'(t_be));
          chk("rnd.mem_wdata", mem_wdata, t_wdata);
        end
        chk("rnd.if_ready", 32'(if_ready), 32'(e_if_ready));
        chk("rnd.dm_ready", 32'(dm_ready), 32'(e_dm_ready));
        chk("rnd.if_rdata", if_rdata, e_if_rdata);
        chk("rnd.dm_rdata", dm_rdata, e_dm_rdata);
        chk("rnd.stall_if", 32'(stall_if), 32'(if_req & ~e_if_ready));
        chk("rnd.stall_mem", 32'(stall_mem), 32'(dm_req & ~e_dm_ready));
        if (if_ready || !if_req) begin
          if_req = $urandom_range(0, 3) < 2;
          if_addr = rnd_addr();
        end
        if (dm_ready || !dm_req) begin
          dm_req = $urandom_range(0, 3) < 2;
          dm_we = 1'($urandom_range(0, 1));
          dm_addr = rnd_addr();
          dm_wdata = $urandom;
          dm_be = 4'($urandom_range(0, 15));
        end
        mem_ack = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
        mem_rdata = mem_req ? phys_rd(mem_addr) : $urandom;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
